ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Decodes the PS/2 scan-code set-2 byte stream from the PS/2 receiver (`received_data` / `received_data_en`) into a registered held-key vector plus one-cycle press/release events for the game logic. It sits between the PS/2 receiver and the player/menu controllers inside `vga_demo`. In simulation, the bench's `sim_received_data` / `sim_received_data_en` drive it directly. It handles the `F0` break prefix, the `E0` extended prefix, the `E1` pause sequence, prefix timeout and keyboard overflow.

## Interface
- `SIMULATION`, 0, when 1 the prefix timeout is 1000 cycles instead of `TIMEOUT_CYCLES`
- `TIMEOUT_CYCLES`, 5_000_000, cycles a pending prefix may wait for its next byte (100 ms at 50 MHz)
- `CLOCK_50`  in  1  system clock, all logic on its rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `received_data`  in  8  scan-code byte, valid only while `received_data_en` is high
- `received_data_en`  in  1  one-cycle strobe, one byte per strobe
- `keys`  out  11  held-key vector:
  - bit 0 W (`1D`), bit 1 A (`1C`), bit 2 S (`1B`), bit 3 D (`23`)
  - bit 4 SPACE (`29`), bit 5 ENTER (`5A`), bit 6 ESC (`76`)
  - bit 7 UP (`E0 75`), bit 8 DOWN (`E0 72`), bit 9 LEFT (`E0 6B`), bit 10 RIGHT (`E0 74`)
- `key_event`  out  1  one-cycle pulse when a bit of `keys` changes
- `key_index`  out  4  index of the bit that changed; held until the next event
- `key_released`  out  1  1 when the event was a release; held until the next event
- `overflow`  out  1  one-cycle pulse on receipt of `00` or `FF`

## Operation
- FSM states: IDLE, BRK (after `F0`), EXT (after `E0`), EXT_BRK (after `E0 F0`), PAUSE (dropping the `E1` sequence).
- IDLE transitions:
  - `F0` → BRK
  - `E0` → EXT
  - `E1` → PAUSE, with the skip counter loaded to 7
  - a known base code → set its bit
  - `00` or `FF` → clear `keys` and pulse `overflow`
  - `AA`, `FA`, `FE` and unknown codes → ignored, stay in IDLE
- BRK: a known base code clears its bit; any byte returns to IDLE.
- EXT: `F0` → EXT_BRK; a known extended code sets its bit and returns to IDLE; any other byte returns to IDLE.
- EXT_BRK: a known extended code clears its bit; any byte returns to IDLE.
- PAUSE: each byte decrements the skip counter; the byte that brings it to 0 returns to IDLE; no outputs change.
- `key_event` fires only on an actual bit transition:
  - make of an already-held key (typematic repeat) → no event
  - break of a key that is not held → no event
- Base codes received in EXT or EXT_BRK are not aliases: `E0 1D` is not W, and is dropped.
- Timeout: in any state other than IDLE, if `TIMEOUT_CYCLES` elapse (1000 when `SIMULATION` = 1) with no strobe, return to IDLE and leave `keys` unchanged. The counter restarts on every strobe.

## Timing
- A byte is accepted on the `CLOCK_50` edge where `received_data_en` = 1.
- `keys`, `key_event`, `key_index`, `key_released`, `overflow` and the FSM state update on that same edge, so they are visible in the cycle after the strobe. Latency is 1 cycle.
- A strobe and a timeout expiring on the same edge: the byte wins and is decoded in the current state.
- Back-to-back strobes on consecutive cycles are all decoded; no byte is lost.
- Reset values: state IDLE, `keys` = 0, `key_event` = 0, `key_index` = 0, `key_released` = 0, `overflow` = 0, counters = 0.
- Reset asserted mid-sequence (for example after `F0`) drops the pending prefix. The first byte after reset is decoded from IDLE.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates; it does not wrap.

## Structure
- Package `ps2_codes_pkg` holds:
  - scan-code constants: `SC_BREAK`=`F0`, `SC_EXT`=`E0`, `SC_PAUSE`=`E1`, the key codes above, `SC_OVF0`/`SC_OVF1`
  - the key-index constants `KEY_W` … `KEY_RIGHT`
  - the FSM state enum
- Sub-module `ps2_timeout_counter`: load/clear on strobe, enable while not IDLE, one-cycle `expired` output.
- The top level holds the FSM, the code→index lookup and the output registers.

## Test plan
- `1D`, then `F0 1D` → after `1D`: `keys[0]`=1, event with index 0, `key_released`=0. After `F0 1D`: `keys[0]`=0, event with index 0, `key_released`=1.
- `E0 75`, `1C`, `E0 F0 75` → `keys` goes `0x080`, then `0x082`, then `0x002`; exactly three `key_event` pulses.
- `1D 1D 1D` (typematic repeat) → a single `key_event`; `F0 23` with D not held → no event.
- `F0`, then 1000 idle cycles with `SIMULATION`=1, then `1D` → the `F0` times out and `1D` is a make: `keys[0]`=1.
- `E1 14 77 E1 F0 14 F0 77` (8-byte pause sequence), then `29` → no output changes during the sequence, then `keys[4]`=1.
- W and UP held, then `FF` → `overflow` pulses and `keys`=0. Reset asserted after `E0` → `keys`=0, and a following `75` is ignored (unknown base code).

Source files
------------

// File: rtl/ps2_key_tracker_pkg.sv
// Scan-code set-2 constants, key indices, FSM states and code->index lookups
// shared by the key tracker and its bench.
package ps2_codes_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_OVF0  = 8'h00;
    localparam logic [7:0] SC_OVF1  = 8'hFF;

    localparam int NUM_KEYS = 11;

    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_SPACE = 4'd4;
    localparam logic [3:0] KEY_ENTER = 4'd5;
    localparam logic [3:0] KEY_ESC   = 4'd6;
    localparam logic [3:0] KEY_UP    = 4'd7;
    localparam logic [3:0] KEY_DOWN  = 4'd8;
    localparam logic [3:0] KEY_LEFT  = 4'd9;
    localparam logic [3:0] KEY_RIGHT = 4'd10;

    // Bytes following E1 that belong to the pause sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, PAUSE} state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_lookup_t;

    function automatic key_lookup_t base_lookup(input logic [7:0] code);
        key_lookup_t r;
        r = '{hit: 1'b1, idx: 4'd0};
        case (code)
            SC_W:     r.idx = KEY_W;
            SC_A:     r.idx = KEY_A;
            SC_S:     r.idx = KEY_S;
            SC_D:     r.idx = KEY_D;
            SC_SPACE: r.idx = KEY_SPACE;
            SC_ENTER: r.idx = KEY_ENTER;
            SC_ESC:   r.idx = KEY_ESC;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic key_lookup_t ext_lookup(input logic [7:0] code);
        key_lookup_t r;
        r = '{hit: 1'b1, idx: 4'd0};
        case (code)
            SC_UP:    r.idx = KEY_UP;
            SC_DOWN:  r.idx = KEY_DOWN;
            SC_LEFT:  r.idx = KEY_LEFT;
            SC_RIGHT: r.idx = KEY_RIGHT;
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte stream in from the PS/2 receiver, held keys and key events out.
interface ps2_key_tracker_if;
    import ps2_codes_pkg::*;

    logic [7:0]          received_data;
    logic                received_data_en;
    logic [NUM_KEYS-1:0] keys;
    logic                key_event;
    logic [3:0]          key_index;
    logic                key_released;
    logic                overflow;

    modport master (
        output received_data, received_data_en,
        input  keys, key_event, key_index, key_released, overflow
    );

    modport slave (
        input  received_data, received_data_en,
        output keys, key_event, key_index, key_released, overflow
    );
endinterface

// File: rtl/ps2_key_tracker_timeout_counter.sv
// Prefix timeout: counts idle cycles while a prefix is pending, restarts on
// every strobe, saturates instead of wrapping.
module ps2_timeout_counter #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] cnt;

    // Clear on strobe or when nothing is pending; otherwise count up to MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= '0;
        else if (strobe || !en)  cnt <= '0;
        else if (cnt != MAX)     cnt <= cnt + 1'b1;
    end

    // Fires on the LIMIT-th idle edge; a strobe on that edge takes priority.
    assign expired = en && !strobe && (cnt == LAST);
endmodule

// File: rtl/ps2_key_tracker.sv
// Scan-code set-2 decoder: prefix FSM, held-key vector and event outputs.
module ps2_key_tracker
    import ps2_codes_pkg::*;
#(
    parameter bit SIMULATION     = 1'b0,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    ps2_key_tracker_if.slave ps2
);
    localparam int LIMIT = SIMULATION ? 1000 : TIMEOUT_CYCLES;

    state_t              state, state_n;
    logic [2:0]          skip, skip_n;
    logic [NUM_KEYS-1:0] keys, keys_n;
    logic                key_event, key_event_n;
    logic [3:0]          key_index, key_index_n;
    logic                key_released, key_released_n;
    logic                overflow, overflow_n;
    logic                expired;
    logic                strobe;
    logic [7:0]          data;
    key_lookup_t         base_lk, ext_lk;

    assign strobe  = ps2.received_data_en;
    assign data    = ps2.received_data;
    assign base_lk = base_lookup(data);
    assign ext_lk  = ext_lookup(data);

    ps2_timeout_counter #(.LIMIT(LIMIT)) u_timeout (
        .clk     (CLOCK_50),
        .rst     (Reset),
        .strobe  (strobe),
        .en      (state != IDLE),
        .expired (expired)
    );

    // State and output registers.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            skip         <= '0;
            keys         <= '0;
            key_event    <= 1'b0;
            key_index    <= '0;
            key_released <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            skip         <= skip_n;
            keys         <= keys_n;
            key_event    <= key_event_n;
            key_index    <= key_index_n;
            key_released <= key_released_n;
            overflow     <= overflow_n;
        end
    end

    // Decode one byte in the current state; events only on real bit changes.
    always_comb begin
        state_n        = state;
        skip_n         = skip;
        keys_n         = keys;
        key_event_n    = 1'b0;
        key_index_n    = key_index;
        key_released_n = key_released;
        overflow_n     = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    if (data == SC_BREAK) state_n = BRK;
                    else if (data == SC_EXT) state_n = EXT;
                    else if (data == SC_PAUSE) begin
                        state_n = PAUSE;
                        skip_n  = PAUSE_SKIP;
                    end else if (data == SC_OVF0 || data == SC_OVF1) begin
                        keys_n     = '0;
                        overflow_n = 1'b1;
                    end else if (base_lk.hit && !keys[base_lk.idx]) begin
                        keys_n[base_lk.idx] = 1'b1;
                        key_event_n         = 1'b1;
                        key_index_n         = base_lk.idx;
                        key_released_n      = 1'b0;
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    if (base_lk.hit && keys[base_lk.idx]) begin
                        keys_n[base_lk.idx] = 1'b0;
                        key_event_n         = 1'b1;
                        key_index_n         = base_lk.idx;
                        key_released_n      = 1'b1;
                    end
                end
                EXT: begin
                    state_n = (data == SC_BREAK) ? EXT_BRK : IDLE;
                    if (ext_lk.hit && !keys[ext_lk.idx]) begin
                        keys_n[ext_lk.idx] = 1'b1;
                        key_event_n        = 1'b1;
                        key_index_n        = ext_lk.idx;
                        key_released_n     = 1'b0;
                    end
                end
                EXT_BRK: begin
                    state_n = IDLE;
                    if (ext_lk.hit && keys[ext_lk.idx]) begin
                        keys_n[ext_lk.idx] = 1'b0;
                        key_event_n        = 1'b1;
                        key_index_n        = ext_lk.idx;
                        key_released_n     = 1'b1;
                    end
                end
                PAUSE: begin
                    skip_n = skip - 3'd1;
                    if (skip <= 3'd1) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (expired) begin
            state_n = IDLE;
        end
    end

    assign ps2.keys         = keys;
    assign ps2.key_event    = key_event;
    assign ps2.key_index    = key_index;
    assign ps2.key_released = key_released;
    assign ps2.overflow     = overflow;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed vector table, hand sequences for
// timeout/pause/overflow/reset, then random bytes against a queue-based model.
module tb_ps2_key_tracker;
    import ps2_codes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_tracker_if bus();

    ps2_key_tracker #(.SIMULATION(1'b1), .TIMEOUT_CYCLES(5_000_000)) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .ps2      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] k;
        logic        ev;
        logic [3:0]  idx;
        logic        rel;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One strobe; returns 1 ns after the accepting edge so outputs are settled.
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(posedge clk);
        #1;
        bus.received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic [10:0] m_keys;
    logic [3:0]  m_idx;
    logic        m_rel;
    logic [7:0]  pq[$];
    int          m_skip;

    function automatic int base_i(input logic [7:0] b);
        case (b)
            8'h1D: return 0;  8'h1C: return 1;  8'h1B: return 2;  8'h23: return 3;
            8'h29: return 4;  8'h5A: return 5;  8'h76: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_i(input logic [7:0] b);
        case (b)
            8'h75: return 7;  8'h72: return 8;  8'h6B: return 9;  8'h74: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        m_keys = '0; m_idx = '0; m_rel = 1'b0; m_skip = 0;
        pq.delete();
    endtask

    task automatic model(input logic [7:0] b, output logic ev, output logic ovf);
        int  i;
        bit  brk, ext;
        ev = 1'b0; ovf = 1'b0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (pq.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pq.push_back(b);
            else if (b == 8'hE1) m_skip = 7;
            else if (b == 8'h00 || b == 8'hFF) begin m_keys = '0; ovf = 1'b1; end
            else begin
                i = base_i(b);
                if (i >= 0 && !m_keys[i]) begin
                    m_keys[i] = 1'b1; ev = 1'b1; m_idx = 4'(i); m_rel = 1'b0;
                end
            end
        end else if (pq.size() == 1 && pq[0] == 8'hE0 && b == 8'hF0) begin
            pq.push_back(b);
        end else begin
            brk = (pq[pq.size()-1] == 8'hF0);
            ext = (pq[0] == 8'hE0);
            i = ext ? ext_i(b) : base_i(b);
            if (i >= 0 && (m_keys[i] == brk)) begin
                m_keys[i] = !brk; ev = 1'b1; m_idx = 4'(i); m_rel = brk;
            end
            pq.delete();
        end
    endtask

    logic [7:0] pool [20] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76,
                             8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hF0, 8'hE0,
                             8'hE0, 8'hAA, 8'h12, 8'hE1, 8'h00, 8'hFF};

    initial begin
        logic [7:0] pseq [8];
        logic       e_ev, e_ovf;
        logic [7:0] b;
        int         g;

        bus.received_data    = '0;
        bus.received_data_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset keys",     32'(bus.keys), 32'h0);
        chk("reset event",    32'(bus.key_event), 32'h0);
        chk("reset index",    32'(bus.key_index), 32'h0);
        chk("reset released", 32'(bus.key_released), 32'h0);
        chk("reset overflow", 32'(bus.overflow), 32'h0);

        // ---------------- directed table ----------------
        tv.push_back('{8'h1D, 11'h001, 1'b1, 4'd0, 1'b0});
        tv.push_back('{8'hF0, 11'h001, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'h1D, 11'h000, 1'b1, 4'd0, 1'b1});
        tv.push_back('{8'hE0, 11'h000, 1'b0, 4'd0, 1'b1});
        tv.push_back('{8'h75, 11'h080, 1'b1, 4'd7, 1'b0});
        tv.push_back('{8'h1C, 11'h082, 1'b1, 4'd1, 1'b0});
        tv.push_back('{8'hE0, 11'h082, 1'b0, 4'd1, 1'b0});
        tv.push_back('{8'hF0, 11'h082, 1'b0, 4'd1, 1'b0});
        tv.push_back('{8'h75, 11'h002, 1'b1, 4'd7, 1'b1});
        tv.push_back('{8'h1D, 11'h003, 1'b1, 4'd0, 1'b0});
        tv.push_back('{8'h1D, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'h1D, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'hF0, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'h23, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'hE0, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'h1D, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'hAA, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'hF0, 11'h003, 1'b0, 4'd0, 1'b0});
        tv.push_back('{8'h1C, 11'h001, 1'b1, 4'd1, 1'b1});
        tv.push_back('{8'hF0, 11'h001, 1'b0, 4'd1, 1'b1});
        tv.push_back('{8'h1D, 11'h000, 1'b1, 4'd0, 1'b1});
        foreach (tv[i]) begin
            put(tv[i].d);
            chk($sformatf("vec%0d keys", i),     32'(bus.keys), 32'(tv[i].k));
            chk($sformatf("vec%0d event", i),    32'(bus.key_event), 32'(tv[i].ev));
            chk($sformatf("vec%0d index", i),    32'(bus.key_index), 32'(tv[i].idx));
            chk($sformatf("vec%0d released", i), 32'(bus.key_released), 32'(tv[i].rel));
        end

        // ---------------- overflow ----------------
        do_reset();
        put(8'h1D); put(8'hE0); put(8'h75);
        chk("ovf pre keys", 32'(bus.keys), 32'h081);
        put(8'hFF);
        chk("ovf pulse", 32'(bus.overflow), 32'h1);
        chk("ovf keys",  32'(bus.keys), 32'h0);
        idle(1);
        chk("ovf one-cycle", 32'(bus.overflow), 32'h0);

        // ---------------- timeout boundary ----------------
        do_reset();
        put(8'h1D); put(8'hF0); idle(999); put(8'h1D);
        chk("to999 keys",     32'(bus.keys), 32'h0);
        chk("to999 released", 32'(bus.key_released), 32'h1);
        do_reset();
        put(8'hF0); idle(1000); put(8'h1D);
        chk("to1000 keys",     32'(bus.keys), 32'h1);
        chk("to1000 event",    32'(bus.key_event), 32'h1);
        chk("to1000 released", 32'(bus.key_released), 32'h0);

        // ---------------- pause sequence ----------------
        do_reset();
        put(8'h1D);
        pseq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        foreach (pseq[i]) begin
            put(pseq[i]);
            chk($sformatf("pause%0d keys", i),  32'(bus.keys), 32'h001);
            chk($sformatf("pause%0d event", i), 32'(bus.key_event), 32'h0);
        end
        put(8'h29);
        chk("pause space keys",  32'(bus.keys), 32'h011);
        chk("pause space index", 32'(bus.key_index), 32'd4);

        // ---------------- reset mid-sequence ----------------
        put(8'hE0);
        do_reset();
        #1;
        chk("rst mid keys", 32'(bus.keys), 32'h0);
        put(8'h75);
        chk("rst 75 keys",  32'(bus.keys), 32'h0);
        chk("rst 75 event", 32'(bus.key_event), 32'h0);
        put(8'h1D); put(8'hF0);
        do_reset();
        put(8'h1D);
        chk("rst brk make", 32'(bus.keys), 32'h1);

        // ---------------- random vs model ----------------
        do_reset();
        model_clear();
        for (int n = 0; n < 400; n++) begin
            b = pool[$urandom_range(0, 19)];
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            put(b);
            model(b, e_ev, e_ovf);
            chk("rnd keys",     32'(bus.keys), 32'(m_keys));
            chk("rnd event",    32'(bus.key_event), 32'(e_ev));
            chk("rnd index",    32'(bus.key_index), 32'(m_idx));
            chk("rnd released", 32'(bus.key_released), 32'(m_rel));
            chk("rnd overflow", 32'(bus.overflow), 32'(e_ovf));
            g = $urandom_range(0, 2);
            if (g > 0) begin
                idle(g);
                chk("rnd gap event", 32'(bus.key_event | bus.overflow), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
